// File: rtl/parking_pkg.sv
// Shared types and helpers for the multi-gate parking occupancy tracker.
package parking_pkg;

  localparam int unsigned MAX_GATES   = 8;
  localparam int unsigned MAX_COUNT_W = 10;
  localparam int unsigned SUM_W       = MAX_COUNT_W + 4;
  localparam int unsigned POP_W       = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6
  } gate_state_e;

  function automatic int unsigned count_width(input int unsigned cap);
    return $clog2(cap + 1);
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_GATES-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_GATES; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

  // Saturate a signed sum into [0, hi]
  function automatic logic signed [SUM_W-1:0] clamp(input logic signed [SUM_W-1:0] x,
                                                    input logic signed [SUM_W-1:0] hi);
    if (x[SUM_W-1]) return '0;
    else if (x > hi) return hi;
    else return x;
  endfunction

endpackage

// File: rtl/parking_lot_multi_gate_if.sv
// Sensor inputs and occupancy/status outputs of the lot tracker.
// PARKING_LOT_REJECT_EN adds the per-gate lot_reject signal.
interface parking_lot_multi_gate_if #(
  parameter int unsigned NUM_GATES = 2,
  parameter int unsigned CAPACITY  = 200
);
  import parking_pkg::*;

  localparam int unsigned COUNT_W = count_width(CAPACITY);

  logic [NUM_GATES-1:0] a;
  logic [NUM_GATES-1:0] b;
  logic [NUM_GATES-1:0] gate_enter;
  logic [NUM_GATES-1:0] gate_exit;
  logic [COUNT_W-1:0]   occupancy;
  logic [COUNT_W-1:0]   free_spaces;
  logic                 full;
  logic                 empty;

`ifdef PARKING_LOT_REJECT_EN
  logic [NUM_GATES-1:0] lot_reject;

  modport master (output a, b,
                  input  gate_enter, gate_exit, occupancy, free_spaces, full, empty, lot_reject);
  modport slave  (input  a, b,
                  output gate_enter, gate_exit, occupancy, free_spaces, full, empty, lot_reject);
`else
  modport master (output a, b,
                  input  gate_enter, gate_exit, occupancy, free_spaces, full, empty);
  modport slave  (input  a, b,
                  output gate_enter, gate_exit, occupancy, free_spaces, full, empty);
`endif

endinterface

// File: rtl/parking_gate_fsm.sv
// Per-gate direction decoder: turns a full a/b beam pass into one-cycle enter/exit pulses.
// PARKING_LOT_REJECT_EN diverts an entry completed while the lot is full to reject.
module parking_gate_fsm
  import parking_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic a,
  input  logic b,
`ifdef PARKING_LOT_REJECT_EN
  input  logic full,
  output logic reject,
`endif
  output logic enter,
  output logic exit
);

  gate_state_e state_q, state_d;
  logic        enter_q, enter_d;
  logic        exit_q,  exit_d;
  logic [1:0]  ab;

`ifdef PARKING_LOT_REJECT_EN
  logic reject_q, reject_d;
  assign reject = reject_q;
`endif

  assign ab    = {a, b};
  assign enter = enter_q;
  assign exit  = exit_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
`ifdef PARKING_LOT_REJECT_EN
      reject_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      enter_q <= enter_d;
      exit_q  <= exit_d;
`ifdef PARKING_LOT_REJECT_EN
      reject_q <= reject_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
`ifdef PARKING_LOT_REJECT_EN
    reject_d = 1'b0;
`endif
    case (state_q)
      IDLE: case (ab)
        2'b10:   state_d = EN1;
        2'b01:   state_d = EX1;
        default: ;
      endcase
      EN1: case (ab)
        2'b11:   state_d = EN2;
        2'b00:   state_d = IDLE;
        default: ;
      endcase
      EN2: case (ab)
        2'b01:   state_d = EN3;
        2'b10:   state_d = EN1;
        2'b00:   state_d = IDLE;
        default: ;
      endcase
      EN3: case (ab)
        2'b00: begin
          state_d = IDLE;
`ifdef PARKING_LOT_REJECT_EN
          if (full) reject_d = 1'b1;
          else      enter_d  = 1'b1;
`else
          enter_d = 1'b1;
`endif
        end
        2'b11:   state_d = EN2;
        2'b10:   state_d = IDLE;
        default: ;
      endcase
      EX1: case (ab)
        2'b11:   state_d = EX2;
        2'b00:   state_d = IDLE;
        default: ;
      endcase
      EX2: case (ab)
        2'b10:   state_d = EX3;
        2'b01:   state_d = EX1;
        2'b00:   state_d = IDLE;
        default: ;
      endcase
      EX3: case (ab)
        2'b00: begin
          state_d = IDLE;
          exit_d  = 1'b1;
        end
        2'b11:   state_d = EX2;
        2'b01:   state_d = IDLE;
        default: ;
      endcase
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/parking_lot_multi_gate.sv
// Multi-gate occupancy tracker: per-gate decoders merged into one saturating counter.
// PARKING_LOT_REJECT_EN enables lot_reject for entries attempted while full.
module parking_lot_multi_gate
  import parking_pkg::*;
#(
  parameter int unsigned NUM_GATES = 2,
  parameter int unsigned CAPACITY  = 200
)(
  input  logic                      clk,
  input  logic                      reset_n,
  parking_lot_multi_gate_if.slave   bus
);

  localparam int unsigned COUNT_W = count_width(CAPACITY);
  localparam int unsigned NET_W   = COUNT_W + 4;

  logic [NUM_GATES-1:0]     gate_enter;
  logic [NUM_GATES-1:0]     gate_exit;
  logic [COUNT_W-1:0]       occupancy_q, occupancy_d;
  logic signed [NET_W-1:0]  net_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic                     full_c;

`ifdef PARKING_LOT_REJECT_EN
  logic [NUM_GATES-1:0] gate_reject;
  assign bus.lot_reject = gate_reject;
`endif

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    parking_gate_fsm u_fsm (
      .clk     (clk),
      .reset_n (reset_n),
      .a       (bus.a[g]),
      .b       (bus.b[g]),
`ifdef PARKING_LOT_REJECT_EN
      .full    (full_c),
      .reject  (gate_reject[g]),
`endif
      .enter   (gate_enter[g]),
      .exit    (gate_exit[g])
    );
  end

  // All gates' pulses net out before saturation, so opposite events cancel cleanly
  always_comb begin
    net_c = $signed(NET_W'(popcount(MAX_GATES'(gate_enter))))
          - $signed(NET_W'(popcount(MAX_GATES'(gate_exit))));
    sum_c = SUM_W'(net_c) + $signed(SUM_W'(occupancy_q));
    occupancy_d = COUNT_W'(clamp(sum_c, $signed(SUM_W'(CAPACITY))));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) occupancy_q <= '0;
    else          occupancy_q <= occupancy_d;
  end

  assign full_c          = (occupancy_q == COUNT_W'(CAPACITY));
  assign bus.gate_enter  = gate_enter;
  assign bus.gate_exit   = gate_exit;
  assign bus.occupancy   = occupancy_q;
  assign bus.free_spaces = COUNT_W'(CAPACITY) - occupancy_q;
  assign bus.full        = full_c;
  assign bus.empty       = (occupancy_q == '0);

endmodule

// File: tb/tb_parking_lot_multi_gate.sv
// Scoreboard bench for parking_lot_multi_gate with two gates and a capacity of three.
module tb_parking_lot_multi_gate;

  localparam int unsigned NG  = 2;
  localparam int unsigned CAP = 3;

  typedef struct {
    logic [1:0] en;
    logic [1:0] ex;
    int         occ;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   pend = 1'b0;
  int   pend_occ = 0;

  always #5 clk = ~clk;

  parking_lot_multi_gate_if #(.NUM_GATES(NG), .CAPACITY(CAP)) bus ();

  parking_lot_multi_gate #(.NUM_GATES(NG), .CAPACITY(CAP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] en, input logic [1:0] ex, input int occ);
    exp_t e;
    e.en = en;
    e.ex = ex;
    e.occ = occ;
    exp_q.push_back(e);
  endtask

  // Hold one {a,b} pair per gate for exactly one sampling edge
  task automatic step(input logic [1:0] g0, input logic [1:0] g1);
    bus.a = {g1[1], g0[1]};
    bus.b = {g1[0], g0[0]};
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(2'b00, 2'b00);
  endtask

  task automatic enter0(input int occ_after);
    step(2'b10, 2'b00);
    step(2'b11, 2'b00);
    step(2'b01, 2'b00);
    push(2'b01, 2'b00, occ_after);
    step(2'b00, 2'b00);
    idle(3);
  endtask

  // Pulses pop the scoreboard; the counter result is checked one cycle later
  always @(negedge clk) begin
    if (pend) begin
      check("occupancy", 32'(bus.occupancy), pend_occ);
      check("free_spaces", 32'(bus.free_spaces), CAP - pend_occ);
      check("full", 32'(bus.full), 32'(pend_occ == CAP));
      check("empty", 32'(bus.empty), 32'(pend_occ == 0));
      pend = 1'b0;
    end
    if (reset_n === 1'b1 && (bus.gate_enter !== 2'b00 || bus.gate_exit !== 2'b00)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: enter=%b exit=%b expected none at %0t",
                 bus.gate_enter, bus.gate_exit, $time);
      end else begin
        cur = exp_q.pop_front();
        check("gate_enter", 32'(bus.gate_enter), 32'(cur.en));
        check("gate_exit", 32'(bus.gate_exit), 32'(cur.ex));
        pend = 1'b1;
        pend_occ = cur.occ;
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_occupancy", 32'(bus.occupancy), 0);
    check("rst_free_spaces", 32'(bus.free_spaces), CAP);
    check("rst_full", 32'(bus.full), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_gate_enter", 32'(bus.gate_enter), 0);
    check("rst_gate_exit", 32'(bus.gate_exit), 0);
    reset_n = 1'b1;
    idle(2);

    // gate0 entry 00,10,11,01,00 -> occupancy 1
    step(2'b00, 2'b00);
    enter0(1);

    // gate1 exit 01,11,10,00 -> occupancy 0
    step(2'b00, 2'b01);
    step(2'b00, 2'b11);
    step(2'b00, 2'b10);
    push(2'b00, 2'b10, 0);
    step(2'b00, 2'b00);
    idle(3);

    // gate0 back-out: no pulse
    step(2'b10, 2'b00);
    step(2'b11, 2'b00);
    step(2'b10, 2'b00);
    step(2'b00, 2'b00);
    idle(3);
    check("backout_occupancy", 32'(bus.occupancy), 0);
    check("backout_empty", 32'(bus.empty), 1);

    // fill to 2, then both gates enter together -> 3, full
    enter0(1);
    enter0(2);
    step(2'b10, 2'b10);
    step(2'b11, 2'b11);
    step(2'b01, 2'b01);
    push(2'b11, 2'b00, 3);
    step(2'b00, 2'b00);
    idle(3);

    // gate1 entry while full: pulse still seen, count saturates at 3
    step(2'b00, 2'b10);
    step(2'b00, 2'b11);
    step(2'b00, 2'b01);
    push(2'b10, 2'b00, 3);
    step(2'b00, 2'b00);
    idle(3);

    // gate0 enter with gate1 exit at full: nets to zero
    step(2'b10, 2'b01);
    step(2'b11, 2'b11);
    step(2'b01, 2'b10);
    push(2'b01, 2'b10, 3);
    step(2'b00, 2'b00);
    idle(3);

    // both exit together -> 1, gate0 exit -> 0, gate1 exit at empty stays 0
    step(2'b01, 2'b01);
    step(2'b11, 2'b11);
    step(2'b10, 2'b10);
    push(2'b00, 2'b11, 1);
    step(2'b00, 2'b00);
    idle(3);
    step(2'b01, 2'b00);
    step(2'b11, 2'b00);
    step(2'b10, 2'b00);
    push(2'b00, 2'b01, 0);
    step(2'b00, 2'b00);
    idle(3);
    step(2'b00, 2'b01);
    step(2'b00, 2'b11);
    step(2'b00, 2'b10);
    push(2'b00, 2'b10, 0);
    step(2'b00, 2'b00);
    idle(3);

    // reset while gate0 sits in EN2, then trailing 01,00 must not pulse
    enter0(1);
    step(2'b10, 2'b00);
    step(2'b11, 2'b00);
    reset_n = 1'b0;
    #1;
    check("midrst_occupancy", 32'(bus.occupancy), 0);
    check("midrst_free_spaces", 32'(bus.free_spaces), CAP);
    check("midrst_full", 32'(bus.full), 0);
    check("midrst_empty", 32'(bus.empty), 1);
    check("midrst_gate_enter", 32'(bus.gate_enter), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(2'b01, 2'b00);
    step(2'b00, 2'b00);
    idle(3);
    check("postrst_occupancy", 32'(bus.occupancy), 0);
    check("postrst_empty", 32'(bus.empty), 1);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
